// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and pixel/flag types for the scanout path.
package vga_pkg;

    // 640x480@60 default timing (pixels / lines)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Wide enough for both 800 columns and 525 lines
    localparam int CNT_W = 10;

    // 12-bit framebuffer pixel {R,G,B}
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Per-tick video flags carried down the alignment pipeline
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } vflags_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus stage-0 decode (active area, sync windows, frame wrap).
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             active0,
    output logic             hs0,
    output logic             vs0,
    output logic             vblank,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic line_end;
    logic frame_end;

    assign line_end  = (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);

    assign active0 = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs0     = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs0     = (vcnt >= VS_BEG) && (vcnt < VS_END);

    // Status outputs are forced low while reset is asserted
    assign vblank      = rst_n && (vcnt >= V_ACT);
    assign frame_start = rst_n && pix_en && frame_end;

    // Advance the raster position once per pixel tick, wrapping line then frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + ONE;
            end else begin
                hcnt <= hcnt + ONE;
            end
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: address generation, read-latency alignment, RGB/sync pins.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SCALE_SHIFT = 2,
    parameter int RD_LATENCY  = 1,
    parameter bit SYNC_NEG    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic        fb_rd_en,
    output logic [7:0]  fb_rd_x,
    output logic [7:0]  fb_rd_y,
    input  logic [11:0] fb_rd_data,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vblank,
    output logic        frame_start
);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             active0;
    logic             hs0;
    logic             vs0;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .active0     (active0),
        .hs0         (hs0),
        .vs0         (vs0),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    // Framebuffer address: live during active video, parked on the last
    // fetched coordinate during blanking so the bus stays quiet.
    logic [7:0] x_cur;
    logic [7:0] y_cur;
    logic [7:0] x_hold;
    logic [7:0] y_hold;

    assign x_cur    = 8'(hcnt >> SCALE_SHIFT);
    assign y_cur    = 8'(vcnt >> SCALE_SHIFT);
    assign fb_rd_en = rst_n && pix_en && active0;
    assign fb_rd_x  = active0 ? x_cur : x_hold;
    assign fb_rd_y  = active0 ? y_cur : y_hold;

    // Remember the most recent fetched address for the blanking interval
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_hold <= '0;
            y_hold <= '0;
        end else if (pix_en && active0) begin
            x_hold <= x_cur;
            y_hold <= y_cur;
        end
    end

    // Delay the stage-0 flags so they line up with the returning read data
    vflags_t stage0;
    vflags_t flag_pipe [RD_LATENCY];
    vflags_t flag_d;

    assign stage0 = '{active: active0, hs: hs0, vs: vs0};
    assign flag_d = flag_pipe[RD_LATENCY-1];

    // Shift flags one slot per pixel tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) flag_pipe[i] <= '0;
        end else if (pix_en) begin
            flag_pipe[0] <= stage0;
            for (int i = 1; i < RD_LATENCY; i++) flag_pipe[i] <= flag_pipe[i-1];
        end
    end

    // Output register: blank forced to black, sync polarity applied here
    rgb_t pix_q;
    logic hs_q;
    logic vs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_q <= '0;
            hs_q  <= SYNC_NEG;
            vs_q  <= SYNC_NEG;
        end else if (pix_en) begin
            pix_q <= flag_d.active ? rgb_t'(fb_rd_data) : '0;
            hs_q  <= flag_d.hs ^ SYNC_NEG;
            vs_q  <= flag_d.vs ^ SYNC_NEG;
        end
    end

    assign vga_r  = pix_q.r;
    assign vga_g  = pix_q.g;
    assign vga_b  = pix_q.b;
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: default horizontal timing, shortened frame
// height so whole-frame behaviour fits in a short run.
module tb_vga_scanout;

    localparam int VA    = 12;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 2;
    localparam int VT    = VA + VF + VS + VB;   // 18 lines
    localparam int HT    = 800;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        fb_rd_en;
    logic [7:0]  fb_rd_x;
    logic [7:0]  fb_rd_y;
    logic [11:0] fb_rd_data = 12'h000;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vblank;
    logic        frame_start;

    int tests = 0;
    int fails = 0;
    int h = 0;
    int v = 0;
    int fs_count = 0;

    always #5 clk = ~clk;

    vga_scanout #(
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .fb_rd_en    (fb_rd_en),
        .fb_rd_x     (fb_rd_x),
        .fb_rd_y     (fb_rd_y),
        .fb_rd_data  (fb_rd_data),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    // Framebuffer contents; (1,0) holds the marker colour F0A
    function automatic logic [11:0] pix(input int x, input int y);
        if (x == 1 && y == 0) return 12'hF0A;
        return {x[3:0], y[3:0], x[7:4] ^ 4'h5};
    endfunction

    // One-tick-latency framebuffer memory
    always @(posedge clk) if (fb_rd_en) fb_rd_data <= pix(int'(fb_rd_x), int'(fb_rd_y));

    always @(posedge clk) if (frame_start) fs_count <= fs_count + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // One clock; track raster position from what the inputs were at the edge
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            h = 0; v = 0;
        end else if (pix_en) begin
            if (h == HT - 1) begin
                h = 0;
                v = (v == VT - 1) ? 0 : v + 1;
            end else begin
                h++;
            end
        end
        #1;
    endtask

    task automatic goto(input int th, input int tv);
        int n = 0;
        pix_en = 1'b1;
        while (!(h == th && v == tv) && n < 2 * FRAME) begin
            tick();
            n++;
        end
    endtask

    // Expected pin values at raster position (hh,vv): two ticks behind
    function automatic logic [11:0] exp_rgb(input int hh, input int vv);
        int p, ph, pv;
        p  = (vv * HT + hh - 2 + FRAME) % FRAME;
        ph = p % HT;
        pv = p / HT;
        if (ph < 640 && pv < VA) return pix(ph >> 2, pv >> 2);
        return 12'h000;
    endfunction

    function automatic logic exp_hs(input int hh, input int vv);
        int ph;
        ph = ((vv * HT + hh - 2 + FRAME) % FRAME) % HT;
        return !(ph >= 656 && ph < 752);
    endfunction

    function automatic logic exp_vs(input int hh, input int vv);
        int pv;
        pv = ((vv * HT + hh - 2 + FRAME) % FRAME) / HT;
        return !(pv >= VA + VF && pv < VA + VF + VS);
    endfunction

    // Whole frame with pix_en toggling every clock, checked tick by tick
    task automatic stall_sweep();
        int bad = 0;
        int fs0 = fs_count;
        logic en_exp;
        for (int c = 0; c < 2 * FRAME; c++) begin
            pix_en = (c % 2 == 0);
            #1;
            en_exp = pix_en && (h < 640) && (v < VA);
            if ({vga_r, vga_g, vga_b} !== exp_rgb(h, v) || vga_hs !== exp_hs(h, v) ||
                vga_vs !== exp_vs(h, v) || fb_rd_en !== en_exp ||
                vblank !== (v >= VA) ||
                frame_start !== (pix_en && h == HT - 1 && v == VT - 1) ||
                (en_exp && (fb_rd_x !== 8'(h >> 2) || fb_rd_y !== 8'(v >> 2)))) begin
                if (bad == 0) $display("[TB] first stall-sweep deviation at h=%0d v=%0d", h, v);
                bad++;
            end
            tick();
        end
        chk("stall_sweep_bad_ticks", bad, 0);
        chk("stall_frame_starts", fs_count - fs0, 1);
    endtask

    initial begin
        int fs_before;

        // Reset held with pix_en high
        rst_n = 1'b0; pix_en = 1'b1;
        repeat (3) tick();
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("rst_hs", vga_hs, 1'b1);
        chk("rst_vs", vga_vs, 1'b1);
        chk("rst_rd_en", fb_rd_en, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_vblank", vblank, 1'b0);

        rst_n = 1'b1; #1;
        chk("first_rd_en", fb_rd_en, 1'b1);
        chk("first_x", fb_rd_x, 8'd0);
        chk("first_y", fb_rd_y, 8'd0);

        // Address mapping and pixel alignment on line 0
        goto(4, 0);   chk("x_at_h4", fb_rd_x, 8'd1);
                      chk("y_at_h4", fb_rd_y, 8'd0);
        goto(5, 0);   chk("rgb_h5", {vga_r, vga_g, vga_b}, 12'h005);
        goto(6, 0);   chk("r_h6", vga_r, 4'hF);
                      chk("g_h6", vga_g, 4'h0);
                      chk("b_h6", vga_b, 4'hA);
        goto(639, 0); chk("x_at_h639", fb_rd_x, 8'd159);
                      chk("rd_en_h639", fb_rd_en, 1'b1);
        goto(640, 0); chk("rd_en_h640", fb_rd_en, 1'b0);
        goto(641, 0); chk("rgb_h641", {vga_r, vga_g, vga_b}, 12'hF0C);
        goto(642, 0); chk("rgb_h642_blank", {vga_r, vga_g, vga_b}, 12'h000);

        // Horizontal sync window
        goto(657, 0); chk("hs_h657", vga_hs, 1'b1);
        goto(658, 0); chk("hs_h658", vga_hs, 1'b0);
        goto(700, 0); chk("x_hold_blank", fb_rd_x, 8'd159);
        goto(753, 0); chk("hs_h753", vga_hs, 1'b0);
        goto(754, 0); chk("hs_h754", vga_hs, 1'b1);
        goto(799, 0); chk("rgb_h799_blank", {vga_r, vga_g, vga_b}, 12'h000);
        goto(1, 1);   chk("rgb_line1_h1", {vga_r, vga_g, vga_b}, 12'h000);
        goto(2, 1);   chk("rgb_line1_h2", {vga_r, vga_g, vga_b}, 12'h005);

        // Last active pixel of the frame and vertical blanking
        goto(639, VA - 1); chk("x_last", fb_rd_x, 8'd159);
                           chk("y_last", fb_rd_y, 8'd2);
                           chk("vblank_active", vblank, 1'b0);
        goto(0, VA);       chk("vblank_set", vblank, 1'b1);
                           chk("rd_en_vblank", fb_rd_en, 1'b0);
        goto(1, 14);       chk("vs_before", vga_vs, 1'b1);
        goto(2, 14);       chk("vs_start", vga_vs, 1'b0);
        goto(1, 16);       chk("vs_end_minus1", vga_vs, 1'b0);
        goto(2, 16);       chk("vs_end", vga_vs, 1'b1);

        // Frame wrap
        goto(HT - 1, VT - 1); chk("frame_start_pulse", frame_start, 1'b1);
        pix_en = 1'b0; #1;
        chk("frame_start_stalled", frame_start, 1'b0);
        chk("rd_en_stalled", fb_rd_en, 1'b0);
        pix_en = 1'b1;
        fs_before = fs_count;
        tick();
        chk("frame_start_counted", fs_count - fs_before, 1);
        chk("frame_start_after", frame_start, 1'b0);
        chk("vblank_wrap", vblank, 1'b0);
        chk("wrap_x", fb_rd_x, 8'd0);
        chk("wrap_y", fb_rd_y, 8'd0);

        // Half-rate frame
        stall_sweep();

        // Mid-frame reset
        goto(300, 10);
        fs_before = fs_count;
        chk("pre_reset_rgb", {vga_r, vga_g, vga_b}, exp_rgb(300, 10));
        rst_n = 1'b0; #1;
        chk("midrst_rd_en", fb_rd_en, 1'b0);
        tick();
        chk("midrst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("midrst_hs", vga_hs, 1'b1);
        chk("midrst_vs", vga_vs, 1'b1);
        chk("midrst_vblank", vblank, 1'b0);
        rst_n = 1'b1; #1;
        chk("postrst_rd_en", fb_rd_en, 1'b1);
        chk("postrst_x", fb_rd_x, 8'd0);
        chk("postrst_y", fb_rd_y, 8'd0);
        goto(1, 0); chk("postrst_rgb_h1", {vga_r, vga_g, vga_b}, 12'h000);
        goto(2, 0); chk("postrst_rgb_h2", {vga_r, vga_g, vga_b}, 12'h005);
        chk("midrst_no_frame_start", fs_count - fs_before, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
